// File: rtl/wb_stage.sv
// Purpose : RV32 writeback stage; aligns/extends load data, selects the writeback value, drives the register file.
// Latency : non-load commits the cycle after capture; a load commits the cycle after its memory response.
// Backpress: in_ready drops only while a load waits for memory; COMMIT accepts the next instruction.
//
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-low reset
//   in_*              retiring instruction from MEM (valid/ready)
//   mem_rsp_valid/mem_rdata  load word from data memory, honoured only while a load is pending
//   rf_RD/rf_regWrite/rf_writeData  register file write port, write enable high one cycle per commit
//   retire_count      instructions retired since reset (wraps)
module wb_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_rd,
    input  logic         in_regWrite,
    input  logic [1:0]   in_wbSel,
    input  logic [n-1:0] in_aluResult,
    input  logic [n-1:0] in_pcPlus4,
    input  logic [n-1:0] in_imm,
    input  logic [2:0]   in_funct3,
    input  logic [1:0]   in_addrLow,
    input  logic         mem_rsp_valid,
    input  logic [n-1:0] mem_rdata,
    output logic [4:0]   rf_RD,
    output logic         rf_regWrite,
    output logic [n-1:0] rf_writeData,
    output logic [n-1:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    state_t     state;

    // Fields of a load held while its data is outstanding.
    logic [4:0] ld_rd;
    logic       ld_regwrite;
    logic [2:0] ld_funct3;
    logic [1:0] ld_addr_low;

    logic       capture;
    logic [n-1:0] nonload_val;

    assign in_ready = (state != WAIT_MEM);
    assign capture  = in_valid & in_ready;

    always_comb begin
        nonload_val = in_aluResult;
        if (in_wbSel == WB_PC4) begin
            nonload_val = in_pcPlus4;
        end else if (in_wbSel == 2'b11) begin
            nonload_val = in_imm;
        end
    end

    // Byte lanes are picked from a 32-bit view of the word; the final cast
    // sign-extends (or truncates) to the datapath width. Halfword selection
    // only looks at addr_low[1], so a misaligned halfword silently rounds down.
    function automatic logic [n-1:0] align_load(
        input logic [n-1:0] word,
        input logic [2:0]   f3,
        input logic [1:0]   addr_low
    );
        logic [31:0] w32;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] ext;
        w32    = 32'(word);
        byte_v = w32[{addr_low, 3'b000} +: 8];
        half_v = w32[{addr_low[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  ext = {{24{byte_v[7]}}, byte_v};
            3'b100:  ext = {24'd0, byte_v};
            3'b001:  ext = {{16{half_v[15]}}, half_v};
            3'b101:  ext = {16'd0, half_v};
            default: ext = w32;
        endcase
        return n'($signed(ext));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ld_rd        <= 5'd0;
            ld_regwrite  <= 1'b0;
            ld_funct3    <= 3'd0;
            ld_addr_low  <= 2'd0;
            rf_RD        <= 5'd0;
            rf_regWrite  <= 1'b0;
            rf_writeData <= '0;
            retire_count <= '0;
        end else begin
            // Write enable is a single-cycle pulse; RD/data hold between commits.
            rf_regWrite <= 1'b0;

            if (state == COMMIT) begin
                retire_count <= retire_count + n'(1);
            end

            case (state)
                IDLE, COMMIT: begin
                    if (capture) begin
                        if (in_wbSel == WB_LOAD) begin
                            ld_rd       <= in_rd;
                            ld_regwrite <= in_regWrite;
                            ld_funct3   <= in_funct3;
                            ld_addr_low <= in_addrLow;
                            state       <= WAIT_MEM;
                        end else begin
                            rf_RD        <= in_rd;
                            rf_writeData <= nonload_val;
                            rf_regWrite  <= in_regWrite & (in_rd != 5'd0);
                            state        <= COMMIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rsp_valid) begin
                        rf_RD        <= ld_rd;
                        rf_writeData <= align_load(mem_rdata, ld_funct3, ld_addr_low);
                        rf_regWrite  <= ld_regwrite & (ld_rd != 5'd0);
                        state        <= COMMIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Purpose : self-checking bench for wb_stage; scoreboard of expected register-file writes plus direct state checks.
// Latency : driver issues at posedge+1, monitor samples at negedge.
// Backpress: driver waits (bounded) on in_ready before presenting an instruction.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regWrite;
    logic [1:0]  in_wbSel;
    logic [31:0] in_aluResult;
    logic [31:0] in_pcPlus4;
    logic [31:0] in_imm;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addrLow;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_RD;
    logic        rf_regWrite;
    logic [31:0] rf_writeData;
    logic [31:0] retire_count;

    // Narrow instance used only to reach the counter wrap in a few hundred cycles.
    logic        w_in_valid;
    logic        w_in_ready;
    logic [4:0]  w_rf_RD;
    logic        w_rf_regWrite;
    logic [7:0]  w_rf_writeData;
    logic [7:0]  w_retire_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    wb_stage #(.n(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_regWrite(in_regWrite), .in_wbSel(in_wbSel),
        .in_aluResult(in_aluResult), .in_pcPlus4(in_pcPlus4), .in_imm(in_imm),
        .in_funct3(in_funct3), .in_addrLow(in_addrLow),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rf_RD(rf_RD), .rf_regWrite(rf_regWrite), .rf_writeData(rf_writeData),
        .retire_count(retire_count)
    );

    wb_stage #(.n(8)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_rd(5'd0), .in_regWrite(1'b1), .in_wbSel(2'b00),
        .in_aluResult(8'h5A), .in_pcPlus4(8'h00), .in_imm(8'h00),
        .in_funct3(3'b010), .in_addrLow(2'b00),
        .mem_rsp_valid(1'b0), .mem_rdata(8'h00),
        .rf_RD(w_rf_RD), .rf_regWrite(w_rf_regWrite), .rf_writeData(w_rf_writeData),
        .retire_count(w_retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write-enable pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && rf_regWrite !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, required no write", rf_RD, rf_writeData);
            end else begin
                chk("commit_rd_data", {27'd0, rf_RD, rf_writeData}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [2:0] f3, input logic [1:0] al,
                         input logic exp_wr, input logic [31:0] exp_dat);
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            tick(1);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
            return;
        end
        in_valid     = 1'b1;
        in_rd        = rd;
        in_regWrite  = rw;
        in_wbSel     = sel;
        in_aluResult = alu;
        in_pcPlus4   = pc4;
        in_imm       = imm;
        in_funct3    = f3;
        in_addrLow   = al;
        if (exp_wr) exp_q.push_back({rd, exp_dat});
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val, input logic exp_wr);
        issue(rd, 1'b1, 2'b00, val, 32'h0, 32'h0, 3'b010, 2'b00, exp_wr, val);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] al,
                        input logic exp_wr, input logic [31:0] exp_dat);
        issue(rd, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, f3, al, exp_wr, exp_dat);
    endtask

    task automatic resp(input logic [31:0] d);
        mem_rsp_valid = 1'b1;
        mem_rdata     = d;
        tick(1);
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_regWrite = 1'b0; in_wbSel = '0;
        in_aluResult = '0; in_pcPlus4 = '0; in_imm = '0; in_funct3 = '0; in_addrLow = '0;
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        w_in_valid = 1'b0;

        // 1. reset then idle
        tick(2);
        chk("rst_regwrite", 64'(rf_regWrite), 64'd0);
        chk("rst_rd", 64'(rf_RD), 64'd0);
        chk("rst_wdata", 64'(rf_writeData), 64'd0);
        chk("rst_retire", 64'(retire_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        tick(5);
        chk("idle_retire", 64'(retire_count), 64'd0);
        chk("idle_wdata", 64'(rf_writeData), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // 2. back-to-back ALU ops, the x0 write is suppressed
        alu_op(5'd5, 32'h11, 1'b1);
        alu_op(5'd6, 32'h22, 1'b1);
        alu_op(5'd0, 32'h33, 1'b0);
        tick(2);
        chk("b2b_retire", 64'(retire_count), 64'd3);

        // 3. load alignment on 0x80F17F84
        load(5'd10, 3'b000, 2'd3, 1'b1, 32'hFFFFFF80); resp(32'h80F17F84);
        load(5'd11, 3'b100, 2'd0, 1'b1, 32'h00000084); resp(32'h80F17F84);
        load(5'd12, 3'b001, 2'd2, 1'b1, 32'hFFFF80F1); resp(32'h80F17F84);
        load(5'd13, 3'b101, 2'd2, 1'b1, 32'h000080F1); resp(32'h80F17F84);
        load(5'd14, 3'b010, 2'd0, 1'b1, 32'h80F17F84); resp(32'h80F17F84);
        load(5'd15, 3'b000, 2'd1, 1'b1, 32'h0000007F); resp(32'h80F17F84);
        load(5'd16, 3'b001, 2'd1, 1'b1, 32'h00007F84); resp(32'h80F17F84);
        tick(2);
        chk("load_retire", 64'(retire_count), 64'd10);

        // 4. load stall; a competing instruction must not be accepted
        load(5'd7, 3'b010, 2'd0, 1'b1, 32'h00000042);
        in_valid = 1'b1; in_rd = 5'd9; in_regWrite = 1'b1; in_wbSel = 2'b00; in_aluResult = 32'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_regwrite", 64'(rf_regWrite), 64'd0);
            tick(1);
        end
        in_valid = 1'b0;
        resp(32'h00000042);
        @(negedge clk);
        chk("commit_in_ready", 64'(in_ready), 64'd1);
        tick(2);
        chk("stall_retire", 64'(retire_count), 64'd11);

        // 5. JAL / LUI select, and a non-writing instruction
        issue(5'd1, 1'b1, 2'b10, 32'hBAD, 32'h104, 32'hFFF, 3'b010, 2'd0, 1'b1, 32'h104);
        issue(5'd2, 1'b1, 2'b11, 32'hBAD, 32'h0, 32'h12345000, 3'b010, 2'd0, 1'b1, 32'h12345000);
        issue(5'd3, 1'b0, 2'b00, 32'h77, 32'h0, 32'h0, 3'b010, 2'd0, 1'b0, 32'h0);
        tick(2);
        chk("sel_retire", 64'(retire_count), 64'd14);

        // 6a. reset while a load is pending, stray response afterwards
        load(5'd8, 3'b010, 2'd0, 1'b0, 32'h0);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_regwrite", 64'(rf_regWrite), 64'd0);
        chk("midrst_rd", 64'(rf_RD), 64'd0);
        chk("midrst_wdata", 64'(rf_writeData), 64'd0);
        chk("midrst_retire", 64'(retire_count), 64'd0);
        tick(1);
        rst = 1'b1;
        resp(32'hDEADBEEF);
        tick(3);
        chk("stray_retire", 64'(retire_count), 64'd0);
        chk("stray_in_ready", 64'(in_ready), 64'd1);
        chk("stray_wdata", 64'(rf_writeData), 64'd0);

        // 6b. counter wrap on the 8-bit instance: 255 retires then one more
        w_in_valid = 1'b1;
        tick(255);
        w_in_valid = 1'b0;
        tick(1);
        @(negedge clk);
        chk("wrap_max", 64'(w_retire_count), 64'hFF);
        w_in_valid = 1'b1;
        tick(1);
        w_in_valid = 1'b0;
        tick(1);
        @(negedge clk);
        chk("wrap_zero", 64'(w_retire_count), 64'h00);

        // drain scoreboard (bounded)
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined RV32 core, directly upstream of the register file.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake and waits for load data from the data memory when required.
- Aligns and sign/zero-extends load data, selects the writeback value, and drives the register file's RD/regWrite/writeData inputs for exactly one cycle per instruction.
- Keeps a retired-instruction counter.

Parameters:
n, 32, datapath width (register/data word width)

Ports:
clk  input  1  clock; stage registers update on posedge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_rd  input  5  destination register
in_regWrite  input  1  instruction writes a register
in_wbSel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 immediate
in_aluResult  input  n  ALU result
in_pcPlus4  input  n  PC+4 (JAL/JALR link)
in_imm  input  n  immediate (LUI)
in_funct3  input  3  load type
in_addrLow  input  2  load byte address bits [1:0]
mem_rsp_valid  input  1  data memory returns load word this cycle
mem_rdata  input  n  raw aligned memory word
rf_RD  output  5  register file RD
rf_regWrite  output  1  register file write enable
rf_writeData  output  n  register file write data
retire_count  output  n  instructions retired since reset

Behaviour:
- States:
  - IDLE: nothing pending.
  - WAIT_MEM: load captured, awaiting data.
  - COMMIT: result valid on rf_* for one cycle.
- Reset (rst=0, async):
  - State IDLE; rf_regWrite=0, rf_RD=0, rf_writeData=0, retire_count=0.
  - in_ready=1 as soon as reset is released.
- in_ready=1 in IDLE and COMMIT; in_ready=0 in WAIT_MEM.
- Capture: at posedge with in_valid&in_ready, latch all in_* fields.
  - in_wbSel!=01: next state COMMIT.
  - in_wbSel==01: next state WAIT_MEM.
- No capture and state COMMIT: next state IDLE.
- COMMIT accepts the next instruction, giving one instruction per cycle for back-to-back non-loads.
- WAIT_MEM:
  - At posedge with mem_rsp_valid=1: align mem_rdata into the result register and go to COMMIT.
  - Otherwise stay; waits indefinitely.
- mem_rsp_valid outside WAIT_MEM is ignored: no state change, data discarded.
- Load alignment (shift by in_addrLow):
  - funct3 000 LB: byte at addrLow*8, sign-extend.
  - funct3 100 LBU: byte at addrLow*8, zero-extend.
  - funct3 001 LH: half at addrLow[1]*16, sign-extend.
  - funct3 101 LHU: half at addrLow[1]*16, zero-extend.
  - funct3 010 and all other encodings: full word.
  - addrLow[0] is ignored for halfwords; no misalignment trap.
- Non-load value per in_wbSel: 00 aluResult, 10 pcPlus4, 11 imm.
- COMMIT outputs (registered, stable from posedge):
  - rf_regWrite = captured regWrite & (captured rd != 0).
  - rf_RD and rf_writeData carry the result.
  - The register file writes at the following negedge.
- Outside COMMIT: rf_regWrite=0; rf_RD/rf_writeData hold the last committed values.
- Latency:
  - Non-load: captured at edge k, rf_regWrite high in cycle k→k+1.
  - Load: response sampled at edge m, rf_regWrite high in cycle m→m+1.
- retire_count:
  - Increments by 1 at the posedge ending each COMMIT cycle, including regWrite=0 and rd=0 instructions.
  - Wraps 2^n−1 → 0.
- Reset mid-operation:
  - Pending load or commit is discarded and the counter clears.
  - A mem_rsp_valid arriving after reset release, with no load outstanding, is ignored.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles → rf_regWrite=0, rf_RD=0, rf_writeData=0, retire_count=0, in_ready=1; rst=1, in_valid=0 for 5 cycles → outputs unchanged.
2. Back-to-back ALU ops: rd=5 alu=0x11, rd=6 alu=0x22, rd=0 alu=0x33 on consecutive cycles → rf_regWrite=1/1/0 in successive cycles, rf_RD=5,6, data 0x11,0x22; x0 not written; retire_count=3.
3. Load alignment: mem_rdata=0x80F17F84:
   - LB addrLow=3 → 0xFFFFFF80.
   - LBU addrLow=0 → 0x00000084.
   - LH addrLow=2 → 0xFFFF80F1.
   - LHU addrLow=2 → 0x000080F1.
   - LW → 0x80F17F84.
4. Load stall: capture load rd=7, mem_rsp_valid held 0 for 4 cycles → in_ready=0 and rf_regWrite=0 throughout; a new in_valid is not accepted. On response, one cycle of rf_regWrite=1 with rf_RD=7; in_ready=1 in that cycle.
5. JAL/LUI select:
   - wbSel=10, pcPlus4=0x104, rd=1 → writeData=0x104.
   - wbSel=11, imm=0x12345000, rd=2 → writeData=0x12345000.
6. Reset mid-load and wrap:
   - rst=0 while in WAIT_MEM, then a mem_rsp_valid after release → no write, retire_count=0.
   - Force retire_count to 0xFFFFFFFF, retire one instruction → 0.
